ahb_clac_mst: RTL and testbench



---
 rtl/ahb_clac_mst_if.sv | 45 ++++
 rtl/ahb_clac_mst.sv | 179 +++++++++++++++++
 tb/tb_ahb_clac_mst.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_clac_mst_if.sv
// Bundle of the command/response handshake and the AHB-Lite master bus
// signals for ahb_clac_mst. The master modport is the DUT view; the slave
// modport is the view of whatever drives commands and models the AHB slave.
interface ahb_clac_mst_if;
    // Command side
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    // Response side
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // AHB-Lite bus
    logic        hsel;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  hready_resp, hresp, hrdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output hsel, hwrite, haddr, hwdata, htrans, hsize, hburst, hready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output hready_resp, hresp, hrdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  hsel, hwrite, haddr, hwdata, htrans, hsize, hburst, hready
    );
endinterface

// File: rtl/ahb_clac_mst.sv
// AHB-Lite single-transfer master. Commands enter an address-phase slot (A),
// advance to a data-phase slot (D) when the slave is ready, and retire as a
// one-cycle response pulse. Back-to-back commands pipeline with no IDLE gap.
// A two-cycle ERROR response or a wait-state timeout cancels the pipelined
// address phase; the cancelled command still gets its own (error) response,
// so responses stay one-per-command and in order.
module ahb_clac_mst #(
    parameter int TIMEOUT = 255
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_clac_mst_if.master bus
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Saturating increment for the wait-state counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Address-phase slot
    logic        a_vld;
    logic        a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;

    // Data-phase slot
    logic        d_vld;
    logic        d_write;
    logic [31:0] hwdata_q;

    // Response register
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    // Error / timeout bookkeeping
    logic [CNT_W-1:0] wait_cnt;
    logic             err_pend;
    logic             cxl_pend;

    logic cmd_ready;
    logic accept;
    logic d_done;
    logic d_wait;
    logic tmo;
    logic err_first;
    logic cxl_issue;
    logic unused_hresp;

    assign cmd_ready = (!a_vld || bus.hready_resp) && !err_pend && !hreset;
    assign accept    = bus.cmd_valid && cmd_ready;

    // D retires normally on any ready edge
    assign d_done    = d_vld && bus.hready_resp;
    assign d_wait    = d_vld && !bus.hready_resp;
    // This edge completes the TIMEOUT-th consecutive wait cycle
    assign tmo       = d_wait && (wait_cnt == CNT_LAST);
    // First cycle of a two-cycle ERROR response; only acted on once
    assign err_first = d_wait && bus.hresp[0] && !err_pend && !tmo;
    // A cancelled command's response goes out once D has emptied, which
    // always places it directly after the aborted/errored D response
    assign cxl_issue = cxl_pend && !d_vld;

    // hresp[1] carries no meaning for AHB-Lite OKAY/ERROR
    assign unused_hresp = bus.hresp[1];

    assign bus.cmd_ready = cmd_ready;
    assign bus.hsel      = a_vld;
    assign bus.htrans    = a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr     = a_addr;
    assign bus.hwrite    = a_write;
    assign bus.hwdata    = hwdata_q;
    assign bus.hsize     = HSIZE_WORD;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.hready    = bus.hready_resp;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Slot advance: load A from the command port, move A to D on ready, cancel on error/timeout
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            a_vld    <= 1'b0;
            a_write  <= 1'b0;
            a_addr   <= '0;
            a_wdata  <= '0;
            d_vld    <= 1'b0;
            d_write  <= 1'b0;
            hwdata_q <= '0;
        end else begin
            if (accept && !err_first) begin
                a_write <= bus.cmd_write;
                a_addr  <= bus.cmd_addr;
                a_wdata <= bus.cmd_wdata;
            end

            if (tmo) begin
                // D abandoned; A (if any) is cancelled, a fresh command may still load
                d_vld <= 1'b0;
                a_vld <= accept;
            end else if (err_first) begin
                // Drive IDLE during the second ERROR cycle
                a_vld <= 1'b0;
            end else if (bus.hready_resp) begin
                d_vld   <= a_vld;
                d_write <= a_write;
                if (a_vld && a_write) begin
                    hwdata_q <= a_wdata;
                end
                a_vld <= accept;
            end else if (accept) begin
                a_vld <= 1'b1;
            end
        end
    end

    // Consecutive wait-state counter for the current data phase
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wait_cnt <= '0;
        end else if (tmo || !d_wait) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= sat_inc(wait_cnt);
        end
    end

    // Response pulse: D completion, D abort, or cancelled-A error response
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (tmo) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
            end else if (d_done) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= bus.hresp[0];
                rsp_rdata_q <= (d_write || bus.hresp[0]) ? 32'h0 : bus.hrdata;
            end else if (cxl_issue) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    // Error-pending and cancelled-command tracking
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            err_pend <= 1'b0;
            cxl_pend <= 1'b0;
        end else if (tmo) begin
            cxl_pend <= cxl_pend || a_vld;
            err_pend <= 1'b0;
        end else if (err_first) begin
            cxl_pend <= a_vld || accept;
            err_pend <= 1'b1;
        end else if (cxl_issue) begin
            cxl_pend <= 1'b0;
            err_pend <= 1'b0;
        end else if (d_done && err_pend && !cxl_pend) begin
            err_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_clac_mst.sv
// Directed bench for ahb_clac_mst: single write, back-to-back reads, wait
// states, two-cycle ERROR with a pipelined command, wait-state timeout and
// asynchronous reset mid-transfer. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_ahb_clac_mst;
    logic hclk = 1'b0;
    logic hreset;
    int   n_cmp = 0;
    int   n_bad = 0;

    ahb_clac_mst_if bus ();

    ahb_clac_mst #(.TIMEOUT(4)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit cv, input bit wr, input logic [31:0] ad,
                          input logic [31:0] wd, input bit rdy, input bit er,
                          input logic [31:0] rd);
        bus.cmd_valid   = cv;
        bus.cmd_write   = wr;
        bus.cmd_addr    = ad;
        bus.cmd_wdata   = wd;
        bus.hready_resp = rdy;
        bus.hresp       = {1'b0, er};
        bus.hrdata      = rd;
    endtask

    task automatic nxt();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_hsel"},      32'(bus.hsel),      0);
        chk({pfx, "_htrans"},    32'(bus.htrans),    0);
        chk({pfx, "_haddr"},     bus.haddr,          0);
        chk({pfx, "_hwrite"},    32'(bus.hwrite),    0);
        chk({pfx, "_hwdata"},    bus.hwdata,         0);
        chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({pfx, "_rsp_rdata"}, bus.rsp_rdata,      0);
        chk({pfx, "_rsp_err"},   32'(bus.rsp_err),   0);
        chk({pfx, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        hreset = 1'b1;
        set_in(0, 0, 0, 0, 1, 0, 0);
        @(negedge hclk);
        chk_reset_outputs("rst");
        chk("rst_hsize",  32'(bus.hsize),  2);
        chk("rst_hburst", 32'(bus.hburst), 0);
        chk("rst_hready", 32'(bus.hready), 1);
        nxt();
        hreset = 1'b0;
        @(negedge hclk);
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 1);
        nxt();

        // ---------------- single write, no waits ----------------
        set_in(1, 1, 32'h4, 32'h0003_0005, 1, 0, 0);
        @(negedge hclk);
        chk("wr_cmd_ready", 32'(bus.cmd_ready), 1);
        nxt();
        set_in(0, 0, 0, 0, 1, 0, 0);
        @(negedge hclk);
        chk("wr_htrans_n1", 32'(bus.htrans), 2);
        chk("wr_haddr_n1",  bus.haddr,       32'h4);
        chk("wr_hwrite_n1", 32'(bus.hwrite), 1);
        chk("wr_hsel_n1",   32'(bus.hsel),   1);
        nxt();
        @(negedge hclk);
        chk("wr_hwdata_n2", bus.hwdata,         32'h0003_0005);
        chk("wr_htrans_n2", 32'(bus.htrans),    0);
        chk("wr_rsp_n2",    32'(bus.rsp_valid), 0);
        nxt();
        @(negedge hclk);
        chk("wr_rsp_n3",   32'(bus.rsp_valid), 1);
        chk("wr_err_n3",   32'(bus.rsp_err),   0);
        chk("wr_rdata_n3", bus.rsp_rdata,      0);
        nxt();
        @(negedge hclk);
        chk("wr_rsp_n4", 32'(bus.rsp_valid), 0);
        nxt();

        // ---------------- three back-to-back reads ----------------
        for (int c = 0; c < 7; c++) begin
            set_in(c < 3, 0, 32'(4 * c), 0, 1, 0,
                   (c >= 2 && c <= 4) ? 32'(17 * (c - 1)) : 32'h0);
            @(negedge hclk);
            if (c >= 1 && c <= 3) begin
                chk("b2b_htrans", 32'(bus.htrans), 2);
                chk("b2b_haddr",  bus.haddr,       32'(4 * (c - 1)));
            end else begin
                chk("b2b_idle", 32'(bus.htrans), 0);
            end
            chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'(c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) begin
                chk("b2b_rdata", bus.rsp_rdata,    32'(17 * (c - 2)));
                chk("b2b_err",   32'(bus.rsp_err), 0);
            end
            nxt();
        end

        // ---------------- write with 2 wait states, then read ----------------
        set_in(1, 1, 32'h4, 32'h0000_00AA, 1, 0, 0);
        nxt();
        set_in(1, 0, 32'h8, 0, 1, 0, 0);
        @(negedge hclk);
        chk("ws_haddr_c1",  bus.haddr,       32'h4);
        chk("ws_hwrite_c1", 32'(bus.hwrite), 1);
        nxt();
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge hclk);
        chk("ws_haddr_c2",     bus.haddr,          32'h8);
        chk("ws_htrans_c2",    32'(bus.htrans),    2);
        chk("ws_hwdata_c2",    bus.hwdata,         32'h0000_00AA);
        chk("ws_cmd_ready_c2", 32'(bus.cmd_ready), 0);
        nxt();
        @(negedge hclk);
        chk("ws_haddr_c3",     bus.haddr,          32'h8);
        chk("ws_htrans_c3",    32'(bus.htrans),    2);
        chk("ws_rsp_c3",       32'(bus.rsp_valid), 0);
        nxt();
        set_in(0, 0, 0, 0, 1, 0, 0);
        @(negedge hclk);
        chk("ws_haddr_c4", bus.haddr,          32'h8);
        chk("ws_rsp_c4",   32'(bus.rsp_valid), 0);
        nxt();
        set_in(0, 0, 0, 0, 1, 0, 32'h55);
        @(negedge hclk);
        chk("ws_wr_rsp",   32'(bus.rsp_valid), 1);
        chk("ws_wr_err",   32'(bus.rsp_err),   0);
        chk("ws_wr_rdata", bus.rsp_rdata,      0);
        chk("ws_idle_c5",  32'(bus.htrans),    0);
        nxt();
        set_in(0, 0, 0, 0, 1, 0, 0);
        @(negedge hclk);
        chk("ws_rd_rsp",   32'(bus.rsp_valid), 1);
        chk("ws_rd_rdata", bus.rsp_rdata,      32'h55);
        nxt();
        @(negedge hclk);
        chk("ws_rsp_c7", 32'(bus.rsp_valid), 0);
        nxt();

        // ---------------- ERROR on read 0x0 with read 0x4 pipelined ----------------
        set_in(1, 0, 32'h0, 0, 1, 0, 0);
        nxt();
        set_in(1, 0, 32'h4, 0, 1, 0, 0);
        nxt();
        set_in(0, 0, 0, 0, 0, 1, 32'hDEAD);
        @(negedge hclk);
        chk("er_htrans_e1", 32'(bus.htrans), 2);
        chk("er_haddr_e1",  bus.haddr,       32'h4);
        nxt();
        set_in(0, 0, 0, 0, 1, 1, 32'hDEAD);
        @(negedge hclk);
        chk("er_htrans_e2",    32'(bus.htrans),    0);
        chk("er_cmd_ready_e2", 32'(bus.cmd_ready), 0);
        chk("er_rsp_e2",       32'(bus.rsp_valid), 0);
        nxt();
        set_in(0, 0, 0, 0, 1, 0, 32'hDEAD);
        @(negedge hclk);
        chk("er_rsp1_valid",  32'(bus.rsp_valid), 1);
        chk("er_rsp1_err",    32'(bus.rsp_err),   1);
        chk("er_rsp1_rdata",  bus.rsp_rdata,      0);
        chk("er_cmd_ready_1", 32'(bus.cmd_ready), 0);
        nxt();
        @(negedge hclk);
        chk("er_rsp2_valid",  32'(bus.rsp_valid), 1);
        chk("er_rsp2_err",    32'(bus.rsp_err),   1);
        chk("er_rsp2_rdata",  bus.rsp_rdata,      0);
        chk("er_cmd_ready_2", 32'(bus.cmd_ready), 1);
        nxt();
        @(negedge hclk);
        chk("er_rsp_after", 32'(bus.rsp_valid), 0);
        nxt();

        // ---------------- timeout (TIMEOUT=4) with pipelined read ----------------
        set_in(1, 0, 32'h10, 0, 1, 0, 0);
        nxt();
        set_in(1, 0, 32'h14, 0, 1, 0, 0);
        nxt();
        for (int c = 2; c < 11; c++) begin
            set_in(0, 0, 0, 0, c >= 9, 0, 32'h77);
            @(negedge hclk);
            if (c <= 5) begin
                chk("to_wait_rsp",   32'(bus.rsp_valid), 0);
                chk("to_wait_ready", 32'(bus.cmd_ready), 0);
                chk("to_wait_haddr", bus.haddr,          32'h14);
            end else if (c == 6) begin
                chk("to_abort_rsp",   32'(bus.rsp_valid), 1);
                chk("to_abort_err",   32'(bus.rsp_err),   1);
                chk("to_abort_rdata", bus.rsp_rdata,      0);
                chk("to_abort_idle",  32'(bus.htrans),    0);
                chk("to_abort_ready", 32'(bus.cmd_ready), 1);
            end else if (c == 7) begin
                chk("to_cxl_rsp", 32'(bus.rsp_valid), 1);
                chk("to_cxl_err", 32'(bus.rsp_err),   1);
            end else begin
                chk("to_quiet_rsp", 32'(bus.rsp_valid), 0);
            end
            nxt();
        end

        // ---------------- asynchronous reset during a data phase ----------------
        set_in(1, 1, 32'h20, 32'h77, 1, 0, 0);
        nxt();
        set_in(0, 0, 0, 0, 1, 0, 0);
        nxt();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ar_hwdata_before", bus.hwdata, 32'h77);
        hreset = 1'b1;
        #1;
        chk_reset_outputs("ar");
        nxt();
        hreset = 1'b0;
        set_in(1, 1, 32'h24, 32'h99, 1, 0, 0);
        @(negedge hclk);
        chk("ar_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("ar_rsp_rel",   32'(bus.rsp_valid), 0);
        nxt();
        set_in(0, 0, 0, 0, 1, 0, 0);
        @(negedge hclk);
        chk("ar_htrans", 32'(bus.htrans),    2);
        chk("ar_haddr",  bus.haddr,          32'h24);
        chk("ar_rsp_n1", 32'(bus.rsp_valid), 0);
        nxt();
        @(negedge hclk);
        chk("ar_hwdata", bus.hwdata,         32'h99);
        chk("ar_rsp_n2", 32'(bus.rsp_valid), 0);
        nxt();
        @(negedge hclk);
        chk("ar_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("ar_rsp_err",   32'(bus.rsp_err),   0);
        nxt();
        @(negedge hclk);
        chk("ar_rsp_after", 32'(bus.rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
